// File: rtl/mem_responder_if.sv
// Memory handshake bundle between a processor-side initiator (MAR/MDR, control
// FSMs) and the memory responder: memEN/RW request, MFC completion.
interface mem_responder_if #(
  parameter int AW = 8,
  parameter int DW = 16
) ();
  logic          memEN;
  logic          RW;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          MFC;
  logic          busy;

  modport master (output memEN, RW, addr, wdata, input rdata, MFC, busy);
  modport slave  (input memEN, RW, addr, wdata, output rdata, MFC, busy);
endinterface

// File: rtl/mem_responder.sv
// Synchronous RAM responder with fixed read/write latency; raises MFC on
// completion and holds it until the initiator drops memEN.
module mem_responder #(
  parameter int AW     = 8,
  parameter int DW     = 16,
  parameter int RD_LAT = 3,
  parameter int WR_LAT = 2
) (
  input logic           clk,
  input logic           rst,
  mem_responder_if.slave bus
);
  localparam int DEPTH = 2 ** AW;
  localparam int LMAX  = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CW    = $clog2(LMAX + 1);

  typedef enum logic [1:0] {IDLE = 2'b00, ACCESS = 2'b01, DONE = 2'b10} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          lat_rw, lat_rw_n;
  logic [AW-1:0] lat_addr, lat_addr_n;
  logic [DW-1:0] rdata_q;
  logic          do_rd, do_wr;
  logic [DW-1:0] mem [DEPTH];

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    lat_rw_n   = lat_rw;
    lat_addr_n = lat_addr;
    do_rd      = 1'b0;
    do_wr      = 1'b0;
    case (state)
      IDLE: if (bus.memEN) begin
        lat_rw_n   = bus.RW;
        lat_addr_n = bus.addr;
        cnt_n      = bus.RW ? CW'(RD_LAT) : CW'(WR_LAT);
        state_n    = ACCESS;
      end
      ACCESS: begin
        if (!bus.memEN) begin
          state_n = IDLE;
        end else if ({bus.RW, bus.addr} != {lat_rw, lat_addr}) begin
          // Command changed under us (e.g. fetch flipping RW): restart the access.
          lat_rw_n   = bus.RW;
          lat_addr_n = bus.addr;
          cnt_n      = bus.RW ? CW'(RD_LAT) : CW'(WR_LAT);
        end else if (cnt == CW'(1)) begin
          do_rd   = lat_rw;
          do_wr   = ~lat_rw;
          state_n = DONE;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      DONE: if (!bus.memEN) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      lat_rw   <= 1'b0;
      lat_addr <= '0;
      rdata_q  <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      lat_rw   <= lat_rw_n;
      lat_addr <= lat_addr_n;
      if (do_rd) rdata_q <= mem[lat_addr];
    end
  end

  // Array is not reset; a write can only fire from ACCESS, which reset leaves.
  always_ff @(posedge clk) begin
    if (do_wr) mem[lat_addr] <= bus.wdata;
  end

  assign bus.rdata = rdata_q;
  assign bus.MFC   = (state == DONE);
  assign bus.busy  = (state != IDLE);
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: read results queued at issue, compared on MFC.
module tb_mem_responder;
  localparam int AW = 8, DW = 16, RD_LAT = 3, WR_LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [DW-1:0] sb [$];

  mem_responder_if #(.AW(AW), .DW(DW)) bus ();
  mem_responder #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.memEN = 1'b1;
    bus.RW    = rw;
    bus.addr  = a;
    bus.wdata = d;
  endtask

  // Counts negedges until MFC; MFC rises one sample after the completion edge.
  task automatic wait_mfc(input string tag, input int lat);
    int n = 0;
    do begin
      tick();
      n++;
      if (n <= lat) chk({tag, "_early"}, {31'b0, bus.MFC}, 32'd0);
    end while (!bus.MFC && n < 20);
    chk({tag, "_lat"}, n - 1, lat);
  endtask

  task automatic pop_rd(input string tag);
    logic [DW-1:0] e;
    e = (sb.size() != 0) ? sb.pop_front() : 'x;
    chk(tag, {16'b0, bus.rdata}, {16'b0, e});
  endtask

  task automatic release_en(input string tag);
    bus.memEN = 1'b0;
    tick();
    chk({tag, "_mfc0"}, {31'b0, bus.MFC}, 32'd0);
    chk({tag, "_busy0"}, {31'b0, bus.busy}, 32'd0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    drive(1'b0, a, d);
    wait_mfc("wr", WR_LAT);
    release_en("wr");
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    drive(1'b1, a, '0);
    sb.push_back(exp);
    wait_mfc("rd", RD_LAT);
    pop_rd("rd_data");
    release_en("rd");
  endtask

  initial begin
    logic [DW-1:0] hold;
    bus.memEN = 1'b0; bus.RW = 1'b0; bus.addr = '0; bus.wdata = '0;
    tick();
    chk("rst_mfc", {31'b0, bus.MFC}, 32'd0);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_rdata", {16'b0, bus.rdata}, 32'd0);
    rst = 1'b1;
    tick();

    // Write then read at 0x05
    wr(8'h05, 16'hBEEF);
    rd(8'h05, 16'hBEEF);

    // Async reset mid-write: outputs clear at once, pending write dropped
    drive(1'b0, 8'h05, 16'h1111);
    tick();
    chk("pre_rst_busy", {31'b0, bus.busy}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_mfc", {31'b0, bus.MFC}, 32'd0);
    chk("arst_busy", {31'b0, bus.busy}, 32'd0);
    chk("arst_rdata", {16'b0, bus.rdata}, 32'd0);
    bus.memEN = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rd(8'h05, 16'hBEEF);

    // Fetch pattern: one cycle as write, then RW flips to read
    wr(8'h10, 16'h1234);
    drive(1'b0, 8'h10, 16'hDEAD);
    tick();
    chk("fetch_busy", {31'b0, bus.busy}, 32'd1);
    bus.RW = 1'b1;
    sb.push_back(16'h1234);
    wait_mfc("fetch", RD_LAT);
    pop_rd("fetch_data");

    // MFC hold in DONE; command changes ignored
    hold = bus.rdata;
    bus.RW = 1'b0; bus.addr = 8'h99; bus.wdata = 16'h7777;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_mfc", {31'b0, bus.MFC}, 32'd1);
      chk("hold_rdata", {16'b0, bus.rdata}, {16'b0, hold});
    end
    release_en("hold");
    rd(8'h10, 16'h1234);

    // Abort: write to 0x20 dropped after one cycle
    wr(8'h20, 16'h5555);
    drive(1'b0, 8'h20, 16'hAAAA);
    tick();
    release_en("abort");
    rd(8'h20, 16'h5555);

    // Restart: read address moves 0x30 -> 0x31 mid-access
    wr(8'h30, 16'h3030);
    wr(8'h31, 16'h3131);
    drive(1'b1, 8'h30, '0);
    tick();
    bus.addr = 8'h31;
    sb.push_back(16'h3131);
    wait_mfc("restart", RD_LAT);
    pop_rd("restart_data");
    release_en("restart");

    chk("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
